// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//
// Purpose:
//    Shared definitions for the nibble-serial adder slice: the controller
//    state encoding, the width of one datapath step, and a helper that turns
//    an operand width into the number of nibble steps needed to add it.
//
// Contents:
//    NIBBLE_W     - bits processed per clock by the nibble datapath (4)
//    state_t      - controller states IDLE / ADD / DONE
//    nibbleCount  - number of nibble steps for a given operand width
// ---------------------------------------------------------------------------
package serial_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Operand width is expected to be a whole number of nibbles; the caller
   // is responsible for rejecting widths that are not.
   function automatic int nibbleCount(input int width);
      return width / NIBBLE_W;
   endfunction

endpackage

// File: rtl/serial_nibble_adder_rca4.sv
// ---------------------------------------------------------------------------
// rca4
//
// Purpose:
//    Plain 4-bit ripple-carry adder. This is the only arithmetic element of
//    the serial adder; the surrounding controller feeds it one nibble of each
//    operand per clock together with the carry saved from the previous step.
//
// Ports:
//    i_a   [3:0]  input   nibble of operand A
//    i_b   [3:0]  input   nibble of operand B
//    i_ci         input   carry into bit 0
//    o_s   [3:0]  output  nibble sum
//    o_co         output  carry out of bit 3
// ---------------------------------------------------------------------------
module rca4 (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_ci,
   output logic [3:0] o_s,
   output logic       o_co
);

   // Carry chain: w_carry[i] is the carry into bit i, w_carry[4] leaves the
   // nibble.
   logic [4:0] w_carry;

   assign w_carry[0] = i_ci;

   // One full adder per bit. The carry is generated when both inputs are set,
   // or propagated when exactly one is set and a carry arrives from below.
   genvar gBit;
   generate
      for (gBit = 0; gBit < 4; gBit++) begin : g_fullAdder
         assign o_s[gBit]         = i_a[gBit] ^ i_b[gBit] ^ w_carry[gBit];
         assign w_carry[gBit + 1] = (i_a[gBit] & i_b[gBit])
                                  | (w_carry[gBit] & (i_a[gBit] ^ i_b[gBit]));
      end
   endgenerate

   assign o_co = w_carry[4];

endmodule

// File: rtl/serial_nibble_adder.sv
// ---------------------------------------------------------------------------
// serial_nibble_adder
//
// Purpose:
//    WIDTH-bit adder that computes {co, s} = a + b + ci one nibble per clock,
//    least-significant nibble first, using a single 4-bit ripple-carry adder.
//    The carry between nibbles is kept in a register. Operands arrive over a
//    valid/ready handshake and the registered result leaves over another.
//    Latency from accept to out_valid is NIB clocks; with out_ready tied high
//    a new add can start every NIB+2 clocks.
//
// Parameters:
//    WIDTH  operand / sum width, a multiple of 4 and at least 4
//
// Ports:
//    clk                  input   rising-edge clock
//    reset                input   asynchronous active-high reset
//    in_valid             input   a, b, ci are valid
//    in_ready             output  block is idle and will take operands
//    a         [WIDTH-1:0] input  operand A
//    b         [WIDTH-1:0] input  operand B
//    ci                   input   carry into nibble 0
//    out_valid            output  s / co hold a completed result
//    out_ready            input   consumer takes the result
//    s         [WIDTH-1:0] output registered sum
//    co                   output  registered carry out of the top nibble
// ---------------------------------------------------------------------------
module serial_nibble_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co
);

   localparam int NIB = nibbleCount(WIDTH);
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

   // Refuse to build for widths that are not a whole number of nibbles;
   // the shift registers below assume an exact nibble count.
   generate
      if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_badWidth
         $error("serial_nibble_adder: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   state_t           r_state;
   logic [WIDTH-1:0] r_opA;
   logic [WIDTH-1:0] r_opB;
   logic             r_carry;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_s;
   logic             r_co;
   logic             r_outValid;

   logic [3:0]       w_sum4;
   logic             w_co4;
   logic [WIDTH-1:0] w_sShift;
   logic             w_last;

   // The single nibble adder always looks at the low nibble of the operand
   // shift registers and the saved carry; the controller decides whether
   // its result is used.
   rca4 u_rca4 (
      .i_a  (r_opA[3:0]),
      .i_b  (r_opB[3:0]),
      .i_ci (r_carry),
      .o_s  (w_sum4),
      .o_co (w_co4)
   );

   // Sum nibbles enter at the top of s and move down one nibble per step,
   // so after NIB steps the first (least significant) nibble sits at s[3:0].
   // A one-nibble adder has nothing to shift down and takes the sum as is.
   generate
      if (NIB == 1) begin : g_oneNibble
         assign w_sShift = w_sum4;
      end else begin : g_multiNibble
         assign w_sShift = {w_sum4, r_s[WIDTH-1:NIBBLE_W]};
      end
   endgenerate

   // True on the step that produces the most significant nibble.
   assign w_last = (r_count == CW'(NIB - 1));

   // Controller and datapath registers. IDLE captures the operands and
   // clears the sum, ADD does one nibble per clock and finishes after the
   // top nibble, DONE holds the result until the consumer takes it. The
   // handshake inputs are only looked at in the state that owns them, so
   // upstream may change a, b, ci freely while an add is in flight. Reset
   // drops everything, including any half-built sum, so an interrupted add
   // never shows up on the output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_opA      <= '0;
         r_opB      <= '0;
         r_carry    <= 1'b0;
         r_count    <= '0;
         r_s        <= '0;
         r_co       <= 1'b0;
         r_outValid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_opA   <= a;
                  r_opB   <= b;
                  r_carry <= ci;
                  r_count <= '0;
                  r_s     <= '0;
                  r_state <= ADD;
               end
            end

            ADD: begin
               r_s     <= w_sShift;
               r_opA   <= r_opA >> NIBBLE_W;
               r_opB   <= r_opB >> NIBBLE_W;
               r_carry <= w_co4;
               r_count <= r_count + CW'(1);
               if (w_last) begin
                  r_co       <= w_co4;
                  r_outValid <= 1'b1;
                  r_state    <= DONE;
               end
            end

            DONE: begin
               if (out_ready) begin
                  r_outValid <= 1'b0;
                  r_state    <= IDLE;
               end
            end

            default: begin
               r_outValid <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   // in_ready is a pure decode of the state register, so it is high
   // straight out of reset and low for the whole of ADD and DONE.
   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_outValid;
   assign s         = r_s;
   assign co        = r_co;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_nibble_adder
//
// Purpose:
//    Self-checking bench for serial_nibble_adder. A 16-bit instance is driven
//    with directed and random operand pairs; each accepted pair pushes its
//    arithmetic sum into a queue and a separate monitor pops and compares
//    whenever the adder presents a result. A 4-bit instance is checked with
//    a short directed/random sequence.
// ---------------------------------------------------------------------------
module tb_serial_nibble_adder;

   localparam int NIB16 = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        inValid = 1'b0;
   logic        outReady = 1'b1;
   logic [15:0] aIn = '0;
   logic [15:0] bIn = '0;
   logic        ciIn = 1'b0;
   logic        inReady;
   logic        outValid;
   logic [15:0] sOut;
   logic        coOut;

   logic        inValid4 = 1'b0;
   logic        outReady4 = 1'b1;
   logic [3:0]  a4 = '0;
   logic [3:0]  b4 = '0;
   logic        ci4 = 1'b0;
   logic        inReady4;
   logic        outValid4;
   logic [3:0]  s4;
   logic        co4;

   int          checks = 0;
   int          failures = 0;
   int          cycleCount = 0;
   bit          randReady = 1'b0;

   logic [16:0] expQ[$];
   int          accQ[$];

   serial_nibble_adder #(.WIDTH(16)) dut16 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .a         (aIn),
      .b         (bIn),
      .ci        (ciIn),
      .out_valid (outValid),
      .out_ready (outReady),
      .s         (sOut),
      .co        (coOut)
   );

   serial_nibble_adder #(.WIDTH(4)) dut4 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (inValid4),
      .in_ready  (inReady4),
      .a         (a4),
      .b         (b4),
      .ci        (ci4),
      .out_valid (outValid4),
      .out_ready (outReady4),
      .s         (s4),
      .co        (co4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount++;

   // Hard stop in case something wedges the whole run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Wait (bounded) for in_ready, present one operand pair, and record its
   // expected sum and accept cycle once the accepting edge has passed.
   // Optionally scrambles the operand inputs while the add is in flight.
   task automatic applyStimulus(input logic [15:0] opA, input logic [15:0] opB,
                                input logic opC, input bit corrupt);
      bit ready = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (inReady) begin
            ready = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ready) begin
         checkOutput("accept_timeout", 32'(inReady), 32'd1);
         return;
      end
      inValid = 1'b1;
      aIn     = opA;
      bIn     = opB;
      ciIn    = opC;
      @(posedge clk); #1;
      expQ.push_back(17'(opA) + 17'(opB) + 17'(opC));
      accQ.push_back(cycleCount);
      inValid = 1'b0;
      if (corrupt) begin
         repeat (NIB16 + 1) begin
            aIn  = 16'($urandom);
            bIn  = 16'($urandom);
            ciIn = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 400; i++) begin
         if ((expQ.size() == 0) && !outValid) break;
         @(posedge clk); #1;
      end
      checkOutput("drain", 32'(expQ.size()), 32'd0);
   endtask

   // Random consumer backpressure, only while enabled.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (randReady) outReady = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: on the first cycle a result is shown, pop and compare value
   // and latency; on later held cycles the result must not move. in_ready
   // must stay low while a result is shown, and a taken result must be gone
   // on the next cycle.
   initial begin
      logic [16:0] curExp;
      int          curAcc;
      bit          haveExp;
      bit          prevValid;
      bit          prevHs;
      haveExp   = 1'b0;
      prevValid = 1'b0;
      prevHs    = 1'b0;
      curExp    = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prevValid = 1'b0;
            prevHs    = 1'b0;
            haveExp   = 1'b0;
         end else begin
            if (prevHs) checkOutput("valid_after_handshake", 32'(outValid), 32'd0);
            if (outValid) begin
               checkOutput("in_ready_while_done", 32'(inReady), 32'd0);
               if (!prevValid) begin
                  if (expQ.size() == 0) begin
                     checkOutput("unexpected_result", 32'({coOut, sOut}), 32'h1ffff);
                     haveExp = 1'b0;
                  end else begin
                     curExp  = expQ.pop_front();
                     curAcc  = accQ.pop_front();
                     haveExp = 1'b1;
                     checkOutput("sum", 32'({coOut, sOut}), 32'(curExp));
                     checkOutput("latency", 32'(cycleCount - curAcc), 32'(NIB16));
                  end
               end else if (haveExp) begin
                  checkOutput("held_result", 32'({coOut, sOut}), 32'(curExp));
               end
            end
            prevValid = outValid;
            prevHs    = outValid && outReady;
         end
      end
   end

   // Main stimulus sequence.
   initial begin
      bit          seen;
      logic [15:0] nextA;
      logic [15:0] nextB;
      logic        nextC;
      logic [3:0]  ta;
      logic [3:0]  tb;
      logic        tc;
      logic [4:0]  exp5;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_in_ready", 32'(inReady), 32'd1);
      checkOutput("rst_out_valid", 32'(outValid), 32'd0);
      checkOutput("rst_result", 32'({coOut, sOut}), 32'd0);
      checkOutput("rst4_state", 32'({inReady4, outValid4, co4, s4}), 32'h40);
      reset = 1'b0;
      @(posedge clk); #1;

      $display("[TB] directed sums");
      outReady = 1'b1;
      applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
      applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b0);
      waitDrain();

      $display("[TB] backpressure");
      outReady = 1'b0;
      applyStimulus(16'h00F0, 16'h0F10, 1'b0, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (outValid) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      checkOutput("bp_result_shown", 32'(seen), 32'd1);
      nextA   = 16'($urandom);
      nextB   = 16'($urandom);
      nextC   = 1'($urandom_range(0, 1));
      inValid = 1'b1;
      aIn     = nextA;
      bIn     = nextB;
      ciIn    = nextC;
      repeat (3) begin
         @(posedge clk); #1;
      end
      outReady = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_idle_after_take", 32'(inReady), 32'd1);
      @(posedge clk); #1;
      expQ.push_back(17'(nextA) + 17'(nextB) + 17'(nextC));
      accQ.push_back(cycleCount);
      inValid = 1'b0;
      checkOutput("bp_reaccepted", 32'(inReady), 32'd0);
      waitDrain();

      $display("[TB] operand corruption during add");
      for (int i = 0; i < 3; i++)
         applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      waitDrain();

      $display("[TB] reset mid-add");
      applyStimulus(16'hABCD, 16'h1111, 1'b1, 1'b0);
      @(posedge clk); #1;
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      checkOutput("midrst_out_valid", 32'(outValid), 32'd0);
      checkOutput("midrst_result", 32'({coOut, sOut}), 32'd0);
      checkOutput("midrst_in_ready", 32'(inReady), 32'd1);
      expQ.delete();
      accQ.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
      waitDrain();

      $display("[TB] random traffic with backpressure");
      randReady = 1'b1;
      for (int i = 0; i < 20; i++)
         applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
      waitDrain();
      randReady = 1'b0;
      outReady  = 1'b1;

      $display("[TB] WIDTH=4 instance");
      for (int t = 0; t < 9; t++) begin
         if (t == 0) begin
            ta = 4'h9;
            tb = 4'h8;
            tc = 1'b0;
         end else begin
            ta = 4'($urandom);
            tb = 4'($urandom);
            tc = 1'($urandom_range(0, 1));
         end
         exp5      = 5'(ta) + 5'(tb) + 5'(tc);
         inValid4  = 1'b1;
         a4        = ta;
         b4        = tb;
         ci4       = tc;
         @(posedge clk); #1;
         inValid4 = 1'b0;
         a4       = 4'($urandom);
         b4       = 4'($urandom);
         checkOutput("w4_not_early", 32'(outValid4), 32'd0);
         @(posedge clk); #1;
         checkOutput("w4_valid", 32'(outValid4), 32'd1);
         checkOutput("w4_sum", 32'({co4, s4}), 32'(exp5));
         @(posedge clk); #1;
         checkOutput("w4_idle", 32'({inReady4, outValid4}), 32'h2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
